// File: rtl/mips_main_control.sv
// mips_main_control: multicycle MIPS main control FSM (fetch/decode/execute/mem/writeback).
// Define MCTRL_MEM_WAIT_EN to stall FETCH, MEMRD and MEMWR until mem_ready.
module mips_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_ADDI  = 6'h08,
  parameter logic [5:0] OP_J     = 6'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
  } state_t;
  state_t cur, nxt;
  logic mem_ok, pc_write, branch;
`ifdef MCTRL_MEM_WAIT_EN
  assign mem_ok = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_ok = 1'b1;
`endif
  always_ff @(posedge clk)
    if (reset) cur <= FETCH;
    else cur <= nxt;
  // Reset forces every enable and select low so an aborted instruction issues no partial write.
  always_comb begin
    nxt = FETCH;
    iord = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    reg_dst = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_op = 2'b00;
    pc_src = 2'b00;
    pc_write = 1'b0;
    branch = 1'b0;
    if (!reset)
      case (cur)
        FETCH: begin
          ir_write = mem_ok;
          pc_write = mem_ok;
          alu_src_b = 2'b01;
          nxt = mem_ok ? DECODE : FETCH;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                op == OP_RTYPE ? RTYPEEX :
                op == OP_BEQ   ? BEQEX :
                op == OP_ADDI  ? ADDIEX :
                op == OP_J     ? JEX : FETCH;
        end
        MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt = op == OP_LW ? MEMRD : op == OP_SW ? MEMWR : FETCH;
        end
        MEMRD: begin
          iord = 1'b1;
          nxt = mem_ok ? MEMWB : MEMRD;
        end
        MEMWB: begin
          reg_write = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEMWR: begin
          iord = 1'b1;
          mem_write = 1'b1;
          nxt = mem_ok ? FETCH : MEMWR;
        end
        RTYPEEX: begin
          alu_src_a = 1'b1;
          alu_op = 2'b10;
          nxt = RTYPEWB;
        end
        RTYPEWB: begin
          reg_write = 1'b1;
          reg_dst = 1'b1;
        end
        BEQEX: begin
          alu_src_a = 1'b1;
          alu_op = 2'b01;
          pc_src = 2'b01;
          branch = 1'b1;
        end
        ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          nxt = ADDIWB;
        end
        ADDIWB: reg_write = 1'b1;
        JEX: begin
          pc_src = 2'b10;
          pc_write = 1'b1;
        end
        default: ;
      endcase
  end
  assign pc_en = pc_write | (branch & zero);
  assign state = cur;
endmodule
